hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit_if.sv | 49 ++++
 rtl/hazard_stall_unit.sv | 136 +++++++++++++
 tb/tb_hazard_stall_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if
//   Groups the pipeline hazard signals exchanged between the datapath and
//   hazard_stall_unit.
//   master : the pipeline side (drives register addresses and stage status,
//            receives stall/flush controls)
//   slave  : the hazard unit itself
//   Signals
//     reg_readaddress1_d/2_d  rs1/rs2 of the instruction in D
//     reg_writeaddress_e      rd of the instruction in E
//     memread_e               instruction in E is a load
//     mul_start_e             multi-cycle multiply entering E this cycle
//     branch_taken_e          branch/jump resolved taken in E
//     dmem_req_m/dmem_ready_m data-memory access active / completing in M
//     stall_f/d/e/m           hold the PC / pipeline register of that stage
//     flush_d/flush_e         insert a bubble into the D/E pipeline register
//     mul_busy                multiply in progress
//     hazard_state            FSM state (00 IDLE, 01 MUL_WAIT, 10 MEM_WAIT)
interface hazard_stall_unit_if;
  logic [4:0] reg_readaddress1_d;
  logic [4:0] reg_readaddress2_d;
  logic [4:0] reg_writeaddress_e;
  logic       memread_e;
  logic       mul_start_e;
  logic       branch_taken_e;
  logic       dmem_req_m;
  logic       dmem_ready_m;
  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       stall_m;
  logic       flush_d;
  logic       flush_e;
  logic       mul_busy;
  logic [1:0] hazard_state;

  modport master (
    output reg_readaddress1_d, reg_readaddress2_d, reg_writeaddress_e,
           memread_e, mul_start_e, branch_taken_e, dmem_req_m, dmem_ready_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
           mul_busy, hazard_state
  );

  modport slave (
    input  reg_readaddress1_d, reg_readaddress2_d, reg_writeaddress_e,
           memread_e, mul_start_e, branch_taken_e, dmem_req_m, dmem_ready_m,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
           mul_busy, hazard_state
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Pipeline hazard controller for a 4-stage F/D/E/M pipeline. Resolves, in
//   priority order every cycle: data-memory wait, multi-cycle multiply,
//   taken branch, load-use.
//   Ports
//     clk    rising-edge pipeline clock
//     rst_n  asynchronous active-low reset (also forces outputs low at once)
//     bus    hazard_stall_unit_if.slave (see interface file for signals)
//   Parameter
//     MUL_LATENCY  cycles a multiply holds the E stage (2..16)
module hazard_stall_unit #(
  parameter int MUL_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_WAIT = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  // The start cycle counts as the first held cycle and the cycle that sees
  // mul_cnt==0 as the last, so the counter is loaded with LATENCY-2.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 2);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_mul_cnt;
  logic [3:0] w_mul_cnt_nxt;
  // Remembers a multiply is still owed cycles while a memory wait
  // interrupts it; mul_cnt alone cannot tell "no multiply" from "last cycle".
  logic       r_mul_act;
  logic       w_mul_act_nxt;

  logic w_mem_stall;
  logic w_load_use;
  logic w_stall_f;
  logic w_stall_d;
  logic w_stall_e;
  logic w_stall_m;
  logic w_flush_d;
  logic w_flush_e;
  logic w_mul_busy;

  // MEM_WAIT keeps stalling until ready even if the request strobe drops.
  assign w_mem_stall = ~bus.dmem_ready_m &
                       (bus.dmem_req_m | (r_state == MEM_WAIT));

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign w_load_use = bus.memread_e & (bus.reg_writeaddress_e != 5'd0) &
                      ((bus.reg_writeaddress_e == bus.reg_readaddress1_d) |
                       (bus.reg_writeaddress_e == bus.reg_readaddress2_d));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mul_cnt <= 4'd0;
      r_mul_act <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
      r_mul_act <= w_mul_act_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    w_mul_act_nxt = r_mul_act;
    w_stall_f     = 1'b0;
    w_stall_d     = 1'b0;
    w_stall_e     = 1'b0;
    w_stall_m     = 1'b0;
    w_flush_d     = 1'b0;
    w_flush_e     = 1'b0;
    w_mul_busy    = r_mul_act;

    if (w_mem_stall) begin
      // Whole pipeline frozen; a pending multiply keeps its count.
      w_stall_f   = 1'b1;
      w_stall_d   = 1'b1;
      w_stall_e   = 1'b1;
      w_stall_m   = 1'b1;
      w_state_nxt = MEM_WAIT;
    end else if (r_mul_act) begin
      // Counting multiply cycle, including the one in which a memory wait
      // releases; a taken branch here is re-presented later since E holds.
      w_stall_f  = 1'b1;
      w_stall_d  = 1'b1;
      w_stall_e  = 1'b1;
      w_mul_busy = 1'b1;
      if (r_mul_cnt != 4'd0) begin
        w_mul_cnt_nxt = r_mul_cnt - 4'd1;
        w_state_nxt   = MUL_WAIT;
      end else begin
        w_mul_act_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    end else if ((r_state == IDLE) && bus.mul_start_e) begin
      w_stall_f     = 1'b1;
      w_stall_d     = 1'b1;
      w_stall_e     = 1'b1;
      w_mul_busy    = 1'b1;
      w_mul_cnt_nxt = MUL_LOAD;
      w_mul_act_nxt = 1'b1;
      w_state_nxt   = MUL_WAIT;
    end else begin
      w_state_nxt = IDLE;
      if (bus.branch_taken_e) begin
        // The flush already removes the dependent instruction, so a
        // coincident load-use needs no stall.
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
      end else if ((r_state == IDLE) && w_load_use) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
    end
  end

  // Outputs are gated by rst_n so they drop the moment reset asserts,
  // regardless of what the inputs are doing.
  assign bus.stall_f      = rst_n & w_stall_f;
  assign bus.stall_d      = rst_n & w_stall_d;
  assign bus.stall_e      = rst_n & w_stall_e;
  assign bus.stall_m      = rst_n & w_stall_m;
  assign bus.flush_d      = rst_n & w_flush_d;
  assign bus.flush_e      = rst_n & w_flush_e;
  assign bus.mul_busy     = rst_n & w_mul_busy;
  assign bus.hazard_state = r_state & {2{rst_n}};

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit
//   Directed bench for hazard_stall_unit with a cycle-level reference model
//   (memory-pending flag plus count of multiply cycles still owed) and
//   hand-computed literal expectations.
//   Output vector bit order: {stall_f, stall_d, stall_e, stall_m,
//                             flush_d, flush_e, mul_busy, hazard_state[1:0]}
module tb_hazard_stall_unit;
  localparam int MUL_LATENCY = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  hazard_stall_unit_if bus ();

  hazard_stall_unit #(.MUL_LATENCY(MUL_LATENCY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] outs;
  assign outs = {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
                 bus.flush_d, bus.flush_e, bus.mul_busy, bus.hazard_state};

  task automatic check(input string name, input logic [8:0] act,
                       input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a multiply owes MUL_LATENCY unfrozen cycles starting
  // with its start cycle; a memory wait freezes everything until ready.
  int         m_mul_rem;
  logic       m_mem_pend;
  logic       m_mem;
  logic       m_act;
  logic       m_idle;
  logic       m_lu;
  logic [1:0] m_st;
  logic [8:0] m_exp;

  always_comb begin
    m_mem  = !bus.dmem_ready_m && (bus.dmem_req_m || m_mem_pend);
    m_act  = (m_mul_rem > 0);
    m_idle = !m_mem_pend && !m_act;
    m_st   = m_mem_pend ? 2'b10 : (m_act ? 2'b01 : 2'b00);
    m_lu   = bus.memread_e && (bus.reg_writeaddress_e != 5'd0) &&
             ((bus.reg_writeaddress_e == bus.reg_readaddress1_d) ||
              (bus.reg_writeaddress_e == bus.reg_readaddress2_d));
    m_exp  = {7'b0, m_st};
    if (m_mem)                            m_exp = {4'b1111, 2'b00, m_act, m_st};
    else if (m_act)                       m_exp = {4'b1110, 2'b00, 1'b1, m_st};
    else if (m_idle && bus.mul_start_e)   m_exp = {4'b1110, 2'b00, 1'b1, m_st};
    else if (bus.branch_taken_e)          m_exp = {4'b0000, 2'b11, 1'b0, m_st};
    else if (m_idle && m_lu)              m_exp = {4'b1100, 2'b01, 1'b0, m_st};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mul_rem  <= 0;
      m_mem_pend <= 1'b0;
    end else if (m_mem) begin
      m_mem_pend <= 1'b1;
    end else begin
      m_mem_pend <= 1'b0;
      if (m_act)                          m_mul_rem <= m_mul_rem - 1;
      else if (m_idle && bus.mul_start_e) m_mul_rem <= MUL_LATENCY - 1;
    end
  end

  // Compare process: every out-of-reset cycle, on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model", outs, m_exp);
      check("stall_flush_excl",
            {7'b0, bus.stall_d & bus.flush_d, bus.stall_e & bus.flush_e},
            9'b0);
    end
  end

  task automatic step(input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] wd, input logic mr, input logic ms,
                      input logic br, input logic rq, input logic rdy);
    @(posedge clk);
    #1;
    bus.reg_readaddress1_d = a1;
    bus.reg_readaddress2_d = a2;
    bus.reg_writeaddress_e = wd;
    bus.memread_e          = mr;
    bus.mul_start_e        = ms;
    bus.branch_taken_e     = br;
    bus.dmem_req_m         = rq;
    bus.dmem_ready_m       = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.reg_readaddress1_d = 5'd0;
    bus.reg_readaddress2_d = 5'd0;
    bus.reg_writeaddress_e = 5'd0;
    bus.memread_e          = 1'b0;
    bus.mul_start_e        = 1'b1;
    bus.branch_taken_e     = 1'b1;
    bus.dmem_req_m         = 1'b1;
    bus.dmem_ready_m       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs, 9'b000000000);
    bus.mul_start_e    = 1'b0;
    bus.branch_taken_e = 1'b0;
    bus.dmem_req_m     = 1'b0;
    bus.dmem_ready_m   = 1'b1;
    rst_n = 1'b1;

    idle();
    check("idle", outs, 9'b000000000);

    // Load x5 in E, D reads x5 as rs2; then bubble in E
    step(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("loaduse_rs2", outs, 9'b110001000);
    idle();
    check("loaduse_after", outs, 9'b000000000);
    // rd = x0 never hazards
    step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("loaduse_x0", outs, 9'b000000000);
    step(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("loaduse_rs1", outs, 9'b110001000);
    step(5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("no_load", outs, 9'b000000000);

    // Branch alone, then branch with load-use
    step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("branch", outs, 9'b000011000);
    step(5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("branch_and_loaduse", outs, 9'b000011000);
    idle();

    // Multiply: 4 held cycles; restart and branch inside are ignored
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("mul_c0", outs, 9'b111000100);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("mul_c1", outs, 9'b111000101);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("mul_c2_branch_ignored", outs, 9'b111000101);
    idle();
    check("mul_c3", outs, 9'b111000101);
    idle();
    check("mul_done", outs, 9'b000000000);

    // Memory wait: 3 not-ready cycles then ready; load-use hidden under it
    step(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mem_c0", outs, 9'b111100000);
    step(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mem_c1", outs, 9'b111100010);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mem_c2", outs, 9'b111100010);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mem_ready", outs, 9'b000000010);
    idle();
    check("mem_done", outs, 9'b000000000);

    // Memory wait of 2 cycles inside a multiply: 6 held cycles in total
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("mulmem_c0", outs, 9'b111000100);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mulmem_c1", outs, 9'b111100101);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mulmem_c2", outs, 9'b111100110);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mulmem_c3", outs, 9'b111000110);
    idle();
    check("mulmem_c4", outs, 9'b111000101);
    idle();
    check("mulmem_c5", outs, 9'b111000101);
    idle();
    check("mulmem_done", outs, 9'b000000000);

    // Memory wait beats a multiply start; start in MEM_WAIT is ignored
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("mem_over_mul", outs, 9'b111100000);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("mul_in_memwait", outs, 9'b000000010);
    idle();
    check("mul_not_started", outs, 9'b000000000);

    // Memory wait hitting the final multiply cycle
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    idle();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mem_last_mul", outs, 9'b111100101);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mem_last_mul_rdy", outs, 9'b111000110);
    idle();
    check("mem_last_done", outs, 9'b000000000);

    // Reset in MUL_WAIT cycle 2 with a memory stall being requested
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    idle();
    check("mul_before_rst", outs, 9'b111000101);
    rst_n = 1'b0;
    bus.dmem_req_m   = 1'b1;
    bus.dmem_ready_m = 1'b0;
    #1;
    check("rst_async", outs, 9'b000000000);
    @(posedge clk);
    #1;
    check("rst_held", outs, 9'b000000000);
    bus.dmem_req_m   = 1'b0;
    bus.dmem_ready_m = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("after_rst_idle", outs, 9'b000000000);
    step(5'd6, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("after_rst_loaduse", outs, 9'b110001000);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
